// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_seq_pkg;

    // Supervisor states, in bring-up order.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        FILTER    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } pll_state_t;

    // Bits needed for one shared counter that must hold the largest of the four limits.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

    // Event counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; clears to 0 on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Each stage simply takes the value of the stage before it.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchroniser stages; the first stage may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: pulses the PLL reset, qualifies lock, then releases the
// downstream resets one by one; any lock loss or relock request starts over.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_OUT        = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILTER    = 1024,
    parameter int RELOCK_TIMEOUT = 65536,
    parameter int STAGGER        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked_i,
    input  logic               relock_req_i,
    output logic               pll_rst_o,
    output logic [NUM_OUT-1:0] out_rst_o,
    output logic               ready_o,
    output logic [7:0]         loss_cnt_o,
    output logic [7:0]         retry_cnt_o
);

    // Counter value at which the last downstream reset has been released.
    localparam int LAST_REL = (NUM_OUT - 1) * STAGGER;
    localparam int CW       = cnt_width(PLL_RST_CYCLES, LOCK_FILTER, RELOCK_TIMEOUT, LAST_REL);

    // Terminal counts, one less than the duration because the entry edge counts as zero.
    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] FLT_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(RELOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] REL_LAST = CW'(LAST_REL);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    pll_state_t         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pll_rst_q, pll_rst_d;
    logic [NUM_OUT-1:0] out_rst_q, out_rst_d;
    logic               ready_q, ready_d;
    logic [7:0]         loss_cnt_q, loss_cnt_d;
    logic [7:0]         retry_cnt_q, retry_cnt_d;
    logic               locked_s;
    logic [NUM_OUT-1:0] rel_done;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_locked_i),
        .q_o   (locked_s)
    );

    // Bit k is due for release once the next counter value reaches k*STAGGER.
    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_rel
            if (gi == 0) begin : g_first
                assign rel_done[gi] = 1'b1;
            end else begin : g_later
                localparam logic [CW-1:0] THR = CW'(gi * STAGGER);
                assign rel_done[gi] = (cnt_d >= THR);
            end
        end
    endgenerate

    // Next-state logic; the single counter restarts from zero on every state entry.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        loss_cnt_d  = loss_cnt_q;
        retry_cnt_d = retry_cnt_q;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (relock_req_i) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end else if (locked_s) begin
                    state_d = FILTER;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d     = RESET_PLL;
                    cnt_d       = '0;
                    retry_cnt_d = sat_inc8(retry_cnt_q);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FILTER: begin
                if (relock_req_i) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end else if (!locked_s) begin
                    // A glitch before qualification is not a loss; just wait again.
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == FLT_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RELEASE: begin
                if (relock_req_i) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end else if (!locked_s) begin
                    state_d    = RESET_PLL;
                    cnt_d      = '0;
                    loss_cnt_d = sat_inc8(loss_cnt_q);
                end else if (cnt_q == REL_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                // Relock takes priority so a coincident lock drop is not counted.
                if (relock_req_i) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end else if (!locked_s) begin
                    state_d    = RESET_PLL;
                    cnt_d      = '0;
                    loss_cnt_d = sat_inc8(loss_cnt_q);
                end
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs follow the next state so they register on the same edge as the transition.
    always_comb begin
        pll_rst_d = (state_d == RESET_PLL);
        ready_d   = (state_d == RUN);
        case (state_d)
            RELEASE: out_rst_d = ~rel_done;
            RUN:     out_rst_d = '0;
            default: out_rst_d = '1;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            out_rst_q   <= '1;
            ready_q     <= 1'b0;
            loss_cnt_q  <= 8'd0;
            retry_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= pll_rst_d;
            out_rst_q   <= out_rst_d;
            ready_q     <= ready_d;
            loss_cnt_q  <= loss_cnt_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign out_rst_o   = out_rst_q;
    assign ready_o     = ready_q;
    assign loss_cnt_o  = loss_cnt_q;
    assign retry_cnt_o = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomised bench for pll_lock_sequencer against a timestamp-based reference model.
module tb_pll_lock_sequencer;

    localparam int NUM_OUT = 3;
    localparam int PRC     = 3;
    localparam int LF      = 4;
    localparam int RT      = 20;
    localparam int STG     = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               lock_in = 1'b0;
    logic               relock_in = 1'b0;
    logic               pll_rst_o;
    logic [NUM_OUT-1:0] out_rst_o;
    logic               ready_o;
    logic [7:0]         loss_cnt_o;
    logic [7:0]         retry_cnt_o;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: phase name plus the edge on which the phase was entered.
    int               n = 0;
    int               m_phase = 0;   // 0 reset-pll, 1 wait, 2 filter, 3 release, 4 run
    int               t_entry = 0;
    int               m_loss = 0;
    int               m_retry = 0;
    bit               ls_p0 = 0;
    bit               ls_p1 = 0;
    bit               m_pll = 1;
    bit               m_ready = 0;
    logic [NUM_OUT-1:0] m_out = '1;
    int               pll_fall = -1;

    pll_lock_sequencer #(
        .NUM_OUT        (NUM_OUT),
        .PLL_RST_CYCLES (PRC),
        .LOCK_FILTER    (LF),
        .RELOCK_TIMEOUT (RT),
        .STAGGER        (STG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked_i (lock_in),
        .relock_req_i (relock_in),
        .pll_rst_o    (pll_rst_o),
        .out_rst_o    (out_rst_o),
        .ready_o      (ready_o),
        .loss_cnt_o   (loss_cnt_o),
        .retry_cnt_o  (retry_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic string pname(input int p);
        case (p)
            0:       return "RESET_PLL";
            1:       return "WAIT_LOCK";
            2:       return "FILTER";
            3:       return "RELEASE";
            default: return "RUN";
        endcase
    endfunction

    task automatic model_outs();
        int e;
        e       = n - t_entry;
        m_pll   = (m_phase == 0);
        m_ready = (m_phase == 4);
        for (int k = 0; k < NUM_OUT; k++) begin
            if (m_phase == 3)      m_out[k] = (e < k * STG);
            else if (m_phase == 4) m_out[k] = 1'b0;
            else                   m_out[k] = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        t_entry = n;
        m_loss  = 0;
        m_retry = 0;
        ls_p0   = 0;
        ls_p1   = 0;
        model_outs();
    endtask

    // One clock edge of the reference: elapsed = edges since the current phase began.
    task automatic model_edge(input bit lk, input bit rq);
        bit ls;
        int e;
        int nxt;
        ls    = ls_p1;
        ls_p1 = ls_p0;
        ls_p0 = lk;
        e     = n - t_entry;
        nxt   = m_phase;
        if (m_phase != 0 && rq) begin
            nxt = 0;
        end else begin
            case (m_phase)
                0: if (e >= PRC) nxt = 1;
                1: begin
                    if (ls) nxt = 2;
                    else if (e >= RT) begin
                        nxt = 0;
                        if (m_retry < 255) m_retry++;
                    end
                end
                2: begin
                    if (!ls) nxt = 1;
                    else if (e >= LF) nxt = 3;
                end
                3: begin
                    if (!ls) begin
                        nxt = 0;
                        if (m_loss < 255) m_loss++;
                    end else if (e > (NUM_OUT - 1) * STG) nxt = 4;
                end
                default: begin
                    if (!ls) begin
                        nxt = 0;
                        if (m_loss < 255) m_loss++;
                    end
                end
            endcase
        end
        if (nxt != m_phase) begin
            $display("cyc=%0d %s -> %s loss=%0d retry=%0d", n, pname(m_phase), pname(nxt), m_loss, m_retry);
            m_phase = nxt;
            t_entry = n;
        end
        model_outs();
    endtask

    // Advance one clock, update the model, then compare all outputs mid-cycle.
    task automatic tick();
        @(posedge clk);
        n++;
        model_edge(lock_in, relock_in);
        @(negedge clk);
        chk("pll_rst", 32'(pll_rst_o), 32'(m_pll));
        chk("out_rst", 32'(out_rst_o), 32'(m_out));
        chk("ready", 32'(ready_o), 32'(m_ready));
        chk("loss_cnt", 32'(loss_cnt_o), 32'(m_loss));
        chk("retry_cnt", 32'(retry_cnt_o), 32'(m_retry));
        if (pll_fall < 0 && pll_rst_o == 1'b0) pll_fall = n;
    endtask

    task automatic wait_run(input string tag, input int budget);
        int k;
        k = 0;
        while (ready_o !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(ready_o), 32'd1);
    endtask

    initial begin
        int g;
        int t_lock;
        int f[NUM_OUT];
        int f_rdy;
        int prev_rise;
        int nper;
        int k;
        logic last_pll;

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        chk("rst_pll", 32'(pll_rst_o), 32'd1);
        chk("rst_out", 32'(out_rst_o), 32'h7);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_loss", 32'(loss_cnt_o), 32'd0);
        chk("rst_retry", 32'(retry_cnt_o), 32'd0);
        n = 0;
        model_reset();
        pll_fall = -1;
        rst_n = 1'b1;

        // Glitch: two lock cycles while waiting must not release anything.
        g = int'($urandom_range(4, 8));
        while (n < g - 1) tick();
        lock_in = 1'b1;
        repeat (2) tick();
        lock_in = 1'b0;
        repeat (4) tick();
        chk("pll_rst_hold", 32'(pll_fall), 32'(PRC));
        chk("glitch_loss", 32'(loss_cnt_o), 32'd0);
        chk("glitch_retry", 32'(retry_cnt_o), 32'd0);
        chk("glitch_out", 32'(out_rst_o), 32'h7);

        // Bring-up: lock sampled at edge t_lock, staggered release afterwards.
        t_lock = n + 1;
        lock_in = 1'b1;
        for (int i = 0; i < NUM_OUT; i++) f[i] = -1;
        f_rdy = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            for (int b = 0; b < NUM_OUT; b++)
                if (f[b] < 0 && out_rst_o[b] == 1'b0) f[b] = n;
            if (f_rdy < 0 && ready_o == 1'b1) f_rdy = n;
        end
        chk("bit0_fall", 32'(f[0]), 32'(t_lock + 6));
        chk("bit1_fall", 32'(f[1]), 32'(t_lock + 8));
        chk("bit2_fall", 32'(f[2]), 32'(t_lock + 10));
        chk("ready_rise", 32'(f_rdy), 32'(t_lock + 11));

        // Loss in RUN: everything reasserted on the third edge.
        lock_in = 1'b0;
        repeat (2) tick();
        chk("loss_ready_hold", 32'(ready_o), 32'd1);
        tick();
        chk("loss_ready", 32'(ready_o), 32'd0);
        chk("loss_out", 32'(out_rst_o), 32'h7);
        chk("loss_pll", 32'(pll_rst_o), 32'd1);
        chk("loss_cnt1", 32'(loss_cnt_o), 32'd1);
        lock_in = 1'b1;
        wait_run("relock_run", 200);

        // Relock request on the same edge the lock drop reaches the FSM.
        lock_in = 1'b0;
        repeat (2) tick();
        relock_in = 1'b1;
        tick();
        relock_in = 1'b0;
        chk("coinc_pll", 32'(pll_rst_o), 32'd1);
        chk("coinc_out", 32'(out_rst_o), 32'h7);
        chk("coinc_ready", 32'(ready_o), 32'd0);
        chk("coinc_loss", 32'(loss_cnt_o), 32'd1);
        lock_in = 1'b1;
        wait_run("coinc_run", 200);

        // Random lock levels and sporadic relock requests.
        for (int s = 0; s < 30; s++) begin
            lock_in = ($urandom_range(0, 2) != 0);
            k = int'($urandom_range(1, 40));
            for (int i = 0; i < k; i++) begin
                relock_in = ($urandom_range(0, 39) == 0);
                tick();
            end
        end
        relock_in = 1'b0;

        // Timeout run: PLL reset re-pulses periodically until retries saturate.
        lock_in = 1'b0;
        prev_rise = -1;
        nper = 0;
        last_pll = pll_rst_o;
        for (int i = 0; i < 260 * (PRC + RT); i++) begin
            tick();
            if (pll_rst_o && !last_pll) begin
                if (prev_rise >= 0 && nper < 3) begin
                    chk("retry_period", 32'(n - prev_rise), 32'(PRC + RT));
                    nper++;
                end
                prev_rise = n;
            end
            last_pll = pll_rst_o;
        end
        chk("retry_sat", 32'(retry_cnt_o), 32'd255);

        // Asynchronous reset in the middle of the staggered release.
        lock_in = 1'b1;
        k = 0;
        while (m_phase != 3 && k < 200) begin
            tick();
            k++;
        end
        chk("rel_bit0", 32'(out_rst_o[0]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pll", 32'(pll_rst_o), 32'd1);
        chk("arst_out", 32'(out_rst_o), 32'h7);
        chk("arst_ready", 32'(ready_o), 32'd0);
        chk("arst_loss", 32'(loss_cnt_o), 32'd0);
        chk("arst_retry", 32'(retry_cnt_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wait_run("post_arst_run", 200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
